// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbitrated adder.
// Imported by the interface, the picker and the top level.
package adder_arb_pkg;

  typedef enum logic {
    IDLE,
    FULL
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Request/response bundle between the clients and the shared adder.
// The arbiter uses the slave modport; the clients use the master modport.
interface adder_rr_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b_i;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic [ID_W-1:0]               rsp_id_o;
  logic [WIDTH-1:0]              rsp_sum_o;
  logic                          rsp_overflow_o;

  modport slave (
    input  req_valid_i,
    input  req_a_i,
    input  req_b_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_id_o,
    output rsp_sum_o,
    output rsp_overflow_o
  );

  modport master (
    output req_valid_i,
    output req_a_i,
    output req_b_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_id_o,
    input  rsp_sum_o,
    input  rsp_overflow_o
  );

endinterface

// File: rtl/adder_rr_arbiter_picker.sv
// Rotating-priority picker: holds the round-robin pointer and finds the first
// valid requester at or above it, wrapping around.
module adder_rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(DEF_NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  input  logic [ID_W-1:0]    take_idx,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic [ID_W-1:0] ptr_q;

  // NUM_REQ is a power of two, so the ID_W-bit increment wraps by itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= take_idx + 1'b1;
    end
  end

  // Scan offsets from the far end so the closest valid index to ptr wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr_q + ID_W'(i);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one WIDTH-bit adder among NUM_REQ clients; one result register with a
// valid/ready response channel, refilled in the same cycle it is drained.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  adder_rr_arbiter_if.slave  bus
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [ID_W-1:0]    winner;
  logic               any_valid;
  logic               can_accept;
  logic               take;
  logic [NUM_REQ-1:0] ready;
  logic [WIDTH:0]     sum_full;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_ovf_q;

  adder_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req       (bus.req_valid_i),
    .take      (take),
    .take_idx  (winner),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign can_accept = (state_q == IDLE) | ((state_q == FULL) & bus.rsp_ready_i);
  assign take       = can_accept & any_valid & rst_ni;

  always_comb begin
    ready = '0;
    if (take) begin
      ready[winner] = bus.req_valid_i[winner];
    end
  end

  assign bus.req_ready_o = ready;

  assign sum_full = {1'b0, bus.req_a_i[winner]} + {1'b0, bus.req_b_i[winner]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A drain without a refill empties the register; a refill always fills it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take) state_d = FULL;
      FULL: begin
        if (take) begin
          state_d = FULL;
        end else if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data is held after it is consumed; only a new grant overwrites it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else if (take) begin
      rsp_id_q  <= winner;
      rsp_sum_q <= sum_full[WIDTH-1:0];
      rsp_ovf_q <= sum_full[WIDTH];
    end
  end

  assign bus.rsp_valid_o    = (state_q == FULL);
  assign bus.rsp_id_o       = rsp_id_q;
  assign bus.rsp_sum_o      = rsp_sum_q;
  assign bus.rsp_overflow_o = rsp_ovf_q;

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Shares one WIDTH-bit unsigned adder among NUM_REQ requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter grants one requester per accepted transaction. The registered sum, carry-out overflow flag and requester ID leave on a single response channel with back-pressure. The block sits between several client blocks and the shared adder datapath and is the only path by which clients reach the adder.

## Interface
- NUM_REQ, 4: number of requesters, ≥2, power of two
- WIDTH, 4: operand and sum width in bits
- clk_i  in  1  single clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit set
- req_a_i  in  NUM_REQ×WIDTH  operand A per requester
- req_b_i  in  NUM_REQ×WIDTH  operand B per requester
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_id_o  out  $clog2(NUM_REQ)  index of the requester that issued the response
- rsp_sum_o  out  WIDTH  sum modulo 2^WIDTH
- rsp_overflow_o  out  1  unsigned carry-out, bit WIDTH of a+b

## Operation
- FSM states:
  - IDLE: result register empty.
  - FULL: result register holds an unconsumed response.
- can_accept = (state==IDLE) | (state==FULL & rsp_ready_i).
- Arbitration: the winner is the first index k with req_valid_i[k] set, searching from ptr upward with wrap-around. This search is combinational.
- req_ready_o[k] = can_accept & (k==winner) & req_valid_i[k]. All other bits are 0.
- Transfer on req_valid_i[k] & req_ready_o[k]. On a transfer:
  - {rsp_overflow_o, rsp_sum_o} <= a_k + b_k, computed at WIDTH+1 bits.
  - rsp_id_o <= k.
  - ptr <= (k+1) mod NUM_REQ.
  - state <= FULL.
- FULL & rsp_ready_i with no new transfer: state <= IDLE. Response data is held, not cleared.
- FULL & !rsp_ready_i: all response outputs stay stable. No request is accepted.
- IDLE with no req_valid_i set: state and ptr are unchanged.
- ptr moves only on a transfer.
- Requesters hold valid and operands until accepted. Dropping valid before acceptance is legal and is simply never granted.

## Timing
- Reset values:
  - rsp_valid_o=0, rsp_sum_o=0, rsp_overflow_o=0, rsp_id_o=0.
  - ptr=0, state=IDLE.
  - req_ready_o=0 while rst_ni is low.
- Latency: a request accepted at edge n is visible on rsp_* after edge n, i.e. 1 cycle.
- rsp_valid_o = (state==FULL), driven from a register.
- Throughput: one transaction per cycle while rsp_ready_i stays high. Simultaneous consume and accept keeps state FULL with the new data.
- req_ready_o depends combinationally on rsp_ready_i and req_valid_i. There is no combinational path from req_a_i or req_b_i to any output.
- Reset asserted mid-transaction: an in-flight response is discarded immediately and asynchronously. No response is ever emitted for it.
- Overflow example for WIDTH=4: 0xF+0x1 gives sum 0x0, overflow 1.

## Structure
- Package adder_arb_pkg holds:
  - typedef enum logic {IDLE, FULL} arb_state_t
  - localparam for the default NUM_REQ and WIDTH
  - function id_width(n) returning $clog2(n)
- Sub-module adder_rr_picker holds the ptr register and the rotate-priority search.
  - Inputs: req mask, grant-taken strobe, granted index.
  - Outputs: winner index, any_valid.
- The top level holds the FSM, the WIDTH+1-bit adder and the response register.

## Test plan
- Single request:
  - Stimulus: after reset, req 2 presents a=0x3, b=0x4 with rsp_ready_i=1.
  - Required response: ready[2] in the same cycle; next cycle rsp_valid=1, id=2, sum=0x7, ovf=0; ptr=3.
- Overflow:
  - Stimulus: req 0 presents a=0xF, b=0x1.
  - Required response: sum=0x0, ovf=1. Then a=0x8, b=0x8 gives sum=0x0, ovf=1. Then a=0x7, b=0x8 gives sum=0xF, ovf=0.
- Round-robin fairness:
  - Stimulus: all 4 requests held valid with rsp_ready_i=1.
  - Required response: grants occur in order 0,1,2,3,0 on consecutive cycles, with rsp_valid high every cycle after the first.
- Back-pressure:
  - Stimulus: rsp_ready_i=0 for 5 cycles with req 1 pending.
  - Required response: the response stays stable and req_ready_o stays 0. When rsp_ready_i rises, req 1 is accepted in that same cycle.
- Wrap and skip:
  - Stimulus: ptr=3, only req 1 valid.
  - Required response: req 1 is granted and ptr becomes 2.
- Reset mid-operation:
  - Stimulus: assert rst_ni low while state is FULL.
  - Required response: rsp_valid_o drops asynchronously. After release, no stale response appears and the first grant goes to the lowest valid index.
